// File: rtl/huff_pkg.sv
// Shared types and defaults for the Huffman accelerator frequency stages.
package huff_pkg;

  localparam int unsigned SymWDefault = 6;
  localparam int unsigned CntWDefault = 8;

  // Count width shared with the bit tallier output.
  typedef logic [CntWDefault-1:0] count_t;

  typedef enum logic [1:0] {
    StAccum,
    StDump,
    StClear
  } state_e;

endpackage

// File: rtl/huff_freq_table.sv
// Register table of per-symbol saturating counters.
// It has one increment port, one asynchronous read port and a clear-all input.
module huff_freq_table
  import huff_pkg::*;
#(
  parameter int unsigned SYM_W = SymWDefault,
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_en_i,
  input  logic [SYM_W-1:0] inc_sym_i,
  output logic             inc_full_o,
  input  logic [SYM_W-1:0] rd_sym_i,
  output logic [CNT_W-1:0] rd_cnt_o
);

  localparam int unsigned Depth = 2 ** SYM_W;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q [Depth];

  assign inc_full_o = (cnt_q[inc_sym_i] == CntMax);
  assign rd_cnt_o   = cnt_q[rd_sym_i];

  // A saturated entry holds its value; the caller raises the sticky flag.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      for (int i = 0; i < Depth; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (inc_en_i && !inc_full_o) begin
      cnt_q[inc_sym_i] <= cnt_q[inc_sym_i] + 1'b1;
    end
  end

endmodule

// File: rtl/huff_freq_accum.sv
// Symbol frequency histogram: accumulate a block, dump (symbol, count) pairs, clear.
// Optional FREQ_SKIP_ZERO_EN: skip zero-count entries and stop the dump at the highest symbol seen.
module huff_freq_accum
  import huff_pkg::*;
#(
  parameter int unsigned SYM_W = SymWDefault,
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [SYM_W-1:0] in_sym_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [SYM_W-1:0] out_sym_o,
  output logic [CNT_W-1:0] out_cnt_o,
  output logic             out_last_o,
  output logic             sat_flag_o
);

  state_e           state_q, state_d;
  logic [SYM_W-1:0] idx_q, idx_d;
  logic [SYM_W-1:0] hi_sym_q, hi_sym_d;
  logic             sat_q, sat_d;

  logic             in_fire, out_fire;
  logic             last_idx;
  logic             inc_full;
  logic [CNT_W-1:0] rd_cnt;

  huff_freq_table #(
    .SYM_W(SYM_W),
    .CNT_W(CNT_W)
  ) u_table (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_q == StClear),
    .inc_en_i  (in_fire),
    .inc_sym_i (in_sym_i),
    .inc_full_o(inc_full),
    .rd_sym_i  (idx_q),
    .rd_cnt_o  (rd_cnt)
  );

  assign in_fire  = in_valid_i && in_ready_o;
  assign out_fire = out_valid_o && out_ready_i;

`ifdef FREQ_SKIP_ZERO_EN
  assign last_idx = (idx_q == hi_sym_q);
`else
  localparam logic [SYM_W-1:0] SymMax = '1;
  assign last_idx = (idx_q == SymMax);
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StAccum;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum: if (in_fire && in_last_i) state_d = StDump;
      StDump: begin
        if (out_fire && out_last_o) begin
          state_d = StClear;
        end
`ifdef FREQ_SKIP_ZERO_EN
        // hi_sym always holds a non-zero count; this only guards against a stuck dump.
        if (!out_valid_o && last_idx) begin
          state_d = StClear;
        end
`endif
      end
      StClear: state_d = StAccum;
      default: state_d = StAccum;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready_o  = (state_q == StAccum);
`ifdef FREQ_SKIP_ZERO_EN
    out_valid_o = (state_q == StDump) && (rd_cnt != '0);
`else
    out_valid_o = (state_q == StDump);
`endif
    out_sym_o   = idx_q;
    out_cnt_o   = (state_q == StDump) ? rd_cnt : '0;
    out_last_o  = out_valid_o && last_idx;
    sat_flag_o  = sat_q;
  end

  // Dump index, highest symbol seen and sticky saturation flag
  always_comb begin
    idx_d    = idx_q;
    hi_sym_d = hi_sym_q;
    sat_d    = sat_q;
    unique case (state_q)
      StAccum: begin
        if (in_fire) begin
          if (in_sym_i > hi_sym_q) hi_sym_d = in_sym_i;
          if (inc_full) sat_d = 1'b1;
        end
      end
      StDump: begin
        if (out_fire && !out_last_o) idx_d = idx_q + 1'b1;
`ifdef FREQ_SKIP_ZERO_EN
        if (!out_valid_o && !last_idx) idx_d = idx_q + 1'b1;
`endif
      end
      StClear: begin
        idx_d    = '0;
        hi_sym_d = '0;
        sat_d    = 1'b0;
      end
      default: begin
        idx_d    = '0;
        hi_sym_d = '0;
        sat_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q    <= '0;
      hi_sym_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      hi_sym_q <= hi_sym_d;
      sat_q    <= sat_d;
    end
  end

endmodule

// File: tb/tb_huff_freq_accum.sv
// Randomized self-checking bench for huff_freq_accum against a histogram reference model.
// Expectations follow FREQ_SKIP_ZERO_EN when it is defined.
module tb_huff_freq_accum;

  localparam int unsigned SymW   = 6;
  localparam int unsigned CntW   = 8;
  localparam int unsigned Depth  = 64;
  localparam int unsigned CntMax = 255;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [SymW-1:0] in_sym;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [SymW-1:0] out_sym;
  logic [CntW-1:0] out_cnt;
  logic            out_last;
  logic            sat_flag;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned hist [Depth];
  bit          model_sat;

  huff_freq_accum #(
    .SYM_W(SymW),
    .CNT_W(CntW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_sym_i   (in_sym),
    .in_last_i  (in_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_sym_o  (out_sym),
    .out_cnt_o  (out_cnt),
    .out_last_o (out_last),
    .sat_flag_o (sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < Depth; i++) hist[i] = 0;
    model_sat = 1'b0;
  endtask

  // Drive one block; optional idle cycles carry junk symbols and junk in_last.
  task automatic send_block(input int unsigned syms[$], input bit idles);
    for (int i = 0; i < syms.size(); i++) begin
      while (idles && $urandom_range(3) == 0) begin
        in_valid = 1'b0;
        in_sym   = SymW'($urandom);
        in_last  = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_sym   = SymW'(syms[i]);
      in_last  = (i == syms.size() - 1);
      check_eq("in_ready_accum", in_ready, 1);
      if (hist[syms[i]] == CntMax) model_sat = 1'b1;
      else hist[syms[i]]++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // mode 0: ready always, 1: one cycle in three, 2: random. abort_at < 0 runs to the end.
  task automatic run_dump(input int mode, input int abort_at);
    int unsigned exp_q[$];
    int          k;
    int          cyc;
    bit          stalled;
    bit          done;
    logic [SymW-1:0] p_sym;
    logic [CntW-1:0] p_cnt;
    logic            p_last;
    k = 0; cyc = 0; stalled = 0; done = 0;
    p_sym = '0; p_cnt = '0; p_last = 1'b0;
    for (int s = 0; s < Depth; s++) begin
`ifdef FREQ_SKIP_ZERO_EN
      if (hist[s] != 0) exp_q.push_back(s);
`else
      exp_q.push_back(s);
`endif
    end
`ifndef FREQ_SKIP_ZERO_EN
    check_eq("first_pair_latency", out_valid, 1);
`endif
    out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom);
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc > 2000) begin
        check_eq("dump_timeout", 0, 1);
        return;
      end
      check_eq("in_ready_dump", in_ready, 0);
      check_eq("sat_flag_dump", sat_flag, model_sat);
      if (stalled && out_valid) begin
        check_eq("stall_sym", out_sym, p_sym);
        check_eq("stall_cnt", out_cnt, p_cnt);
        check_eq("stall_last", out_last, p_last);
      end
      if (abort_at >= 0 && k == abort_at) return;
      if (out_valid) begin
        if (k >= exp_q.size()) begin
          check_eq("extra_pair", 1, 0);
          return;
        end
        check_eq("pair_sym", out_sym, exp_q[k]);
        check_eq("pair_cnt", out_cnt, hist[exp_q[k]]);
        check_eq("pair_last", out_last, (k == exp_q.size() - 1));
        if (out_ready) begin
          k++;
          if (out_last) done = 1;
        end
        stalled = !out_ready;
        p_sym = out_sym; p_cnt = out_cnt; p_last = out_last;
      end else begin
        stalled = 0;
      end
      @(posedge clk); #1;
      if (mode == 1) out_ready = (cyc % 3 == 2);
      else if (mode == 2) out_ready = 1'($urandom);
    end
    @(negedge clk);
    check_eq("pair_count", k, exp_q.size());
    check_eq("clear_out_valid", out_valid, 0);
    check_eq("clear_in_ready", in_ready, 0);
    @(posedge clk); #1;
    model_reset();
    check_eq("rearm_in_ready", in_ready, 1);
    check_eq("rearm_sat_flag", sat_flag, 0);
    check_eq("rearm_out_valid", out_valid, 0);
  endtask

  initial begin
    int unsigned blk[$];
    rst = 1'b1; in_valid = 1'b0; in_sym = '0; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_sym", out_sym, 0);
    check_eq("rst_out_cnt", out_cnt, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_sat_flag", sat_flag, 0);

    blk = '{3, 3, 3, 7};
    send_block(blk, 0);
    run_dump(0, -1);

    blk = {};
    for (int i = 0; i < 300; i++) blk.push_back(5);
    send_block(blk, 0);
    check_eq("sat_model", model_sat, 1);
    run_dump(0, -1);

    blk = {};
    for (int i = 0; i < 50; i++) blk.push_back($urandom_range(Depth - 1));
    send_block(blk, 1);
    run_dump(1, -1);

    blk = '{1, 1};
    send_block(blk, 0);
    run_dump(0, -1);
    blk = '{2};
    send_block(blk, 0);
    run_dump(0, -1);

    blk = {};
    for (int i = 0; i < 40; i++) blk.push_back(i);
    send_block(blk, 0);
    run_dump(0, 20);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    check_eq("midrst_out_sym", out_sym, 0);
    @(posedge clk); #1;
    check_eq("midrst_idle_valid", out_valid, 0);
    blk = '{9};
    send_block(blk, 0);
    run_dump(0, -1);

    blk = '{4, 10, 4};
    send_block(blk, 1);
    run_dump(0, -1);

    for (int b = 0; b < 4; b++) begin
      int unsigned span;
      int unsigned len;
      blk  = {};
      span = $urandom_range(Depth - 1, 1);
      len  = $urandom_range(80, 1);
      for (int i = 0; i < len; i++) blk.push_back($urandom_range(span));
      send_block(blk, 1);
      run_dump(2, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/huff_freq_accum.md
Name: huff_freq_accum

Overview:
- Downstream stage of the bit tallier in the Huffman accelerator.
- Accepts a stream of symbols with a valid/ready handshake and builds a per-symbol frequency histogram in a register table.
- When a block ends, it dumps (symbol, count) pairs to the Huffman tree builder, clears the table and re-arms for the next block.

Parameters:
- SYM_W, 6, symbol width in bits; table depth is 2^SYM_W (64 at default).
- CNT_W, 8, width of each frequency counter; counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  symbol present on in_sym.
- in_ready  output  1  block can accept a symbol this cycle.
- in_sym  input  SYM_W  symbol value.
- in_last  input  1  marks the final symbol of a block; sampled only on an accepted transfer.
- out_valid  output  1  out_sym and out_cnt hold a valid pair.
- out_ready  input  1  downstream accepts the pair.
- out_sym  output  SYM_W  symbol index being reported.
- out_cnt  output  CNT_W  frequency of out_sym.
- out_last  output  1  final pair of the dump.
- sat_flag  output  1  sticky; some counter saturated in the current block.

Behaviour:
- Reset:
  - Synchronous, active-high.
  - State goes to ACCUM and all counters go to 0.
  - Outputs: in_ready=1, out_valid=0, out_sym=0, out_cnt=0, out_last=0, sat_flag=0.
  - Internal dump index=0 and hi_sym=0.
  - Reset during DUMP or CLEAR aborts the block; no further out_valid is asserted.
- A transfer occurs when valid and ready are both high on a rising edge.
- State ACCUM:
  - in_ready=1 and out_valid=0.
  - Each accepted symbol does count[in_sym] <= count[in_sym]+1.
  - If the count is already 2^CNT_W-1, it holds that value and sat_flag <= 1.
  - The update is single-cycle read-modify-write, so back-to-back repeats of the same symbol must each count; the result is visible on the next cycle.
  - hi_sym <= max(hi_sym, in_sym) on each accepted symbol.
  - An accepted symbol with in_last=1 is counted, and the state moves to DUMP on the next cycle.
- State DUMP:
  - in_ready=0 and out_valid=1.
  - out_sym = dump index; out_cnt = count[index].
  - On an out transfer, the index increments.
  - out_sym, out_cnt and out_last must stay stable while out_valid=1 and out_ready=0.
  - out_last=1 when the index is 2^SYM_W-1, or the last reported index under FREQ_SKIP_ZERO_EN.
  - A transfer with out_last=1 moves the state to CLEAR.
- State CLEAR (exactly 1 cycle):
  - in_ready=0 and out_valid=0.
  - All counters, sat_flag, hi_sym and the index are zeroed.
  - Next state is ACCUM.
- Latency and throughput:
  - First pair is valid 1 cycle after the in_last transfer.
  - A full dump takes 2^SYM_W cycles at out_ready=1.
  - Block-to-block gap is 1 cycle (CLEAR).
- Boundaries:
  - A block of a single symbol is legal.
  - in_sym with in_valid=0 is ignored.
  - in_last without in_valid has no effect.

Optional Feature:
- Macro FREQ_SKIP_ZERO_EN.
- When defined:
  - DUMP skips indices whose count is 0, advancing through them without asserting out_valid (one index per cycle).
  - out_last is asserted on the pair whose index equals hi_sym.
  - The dump ends there; indices above hi_sym are never visited.
- When undefined: all 2^SYM_W entries are reported, including zero counts.

Decomposition:
- Shared package huff_pkg holds:
  - the state enum (ACCUM, DUMP, CLEAR);
  - the SYM_W and CNT_W defaults;
  - a count_t typedef, shared with the tallier output width (8).
- One sub-module: huff_freq_table. It holds the counter register array with a saturating increment port, an async read port for the dump, and a clear-all input.
- The FSM and handshakes stay in the top module.

Test Plan:
- Symbols 3,3,3,7 (last on 7), out_ready=1 -> 64 pairs; pair 3 cnt=3, pair 7 cnt=1, all others 0; out_last only on sym 63.
- Symbol 5 sent 300 times back-to-back, last on the 300th -> pair 5 cnt=255 and sat_flag=1; after CLEAR, sat_flag=0.
- During DUMP, toggle out_ready with a 1-in-3 pattern -> no lost or duplicated pairs; fields stable while stalled; in_ready=0 throughout.
- Two blocks back-to-back ({1,1} then {2}) -> second dump shows cnt[1]=0 and cnt[2]=1; exactly one CLEAR cycle with both valids low.
- Assert rst midway through a dump at index 20 -> next cycle out_valid=0 and in_ready=1; a subsequent block {9} dumps cnt[9]=1 only.
- With FREQ_SKIP_ZERO_EN, symbols {4,10,4} -> exactly two pairs (4,2) and (10,1); out_last on the 10 pair; then CLEAR.
